mas8_seq: RTL and testbench
===========================

# mas8_seq

Instruction sequencer and memory port for the MAS8 core. It fetches two-byte instructions from a shared 8-bit memory over a req/ack handshake and decodes them onto the ALU's `opcode`/`rd`/`ra`/`c`/`din`/`en` inputs. It consumes the ALU's `radr` output and register values to execute jumps, loads and stores. The block sits between `ALU_8b` and the single memory port; the ALU itself stays purely an executor.

## Interface
- `RESET_PC`, default 8'h00: fetch address after reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rstz`  in  1  asynchronous, active-high reset (1 = reset).
- `reg0`..`reg3`  in  8 each  ALU register values, used for effective address and store data.
- `radr`  in  8  ALU address output; sampled only in EXEC for jumps.
- `opcode`  out  4  IR[7:4], registered.
- `rd`  out  2  IR[3:2], registered.
- `ra`  out  2  IR[1:0], registered.
- `c`  out  8  second instruction byte, registered.
- `din`  out  8  load data to ALU, registered.
- `en`  out  1  ALU enable, one-cycle pulse in EXEC.
- `mem_req`  out  1  memory request; held until ack.
- `mem_we`  out  1  1 = write, valid with `mem_req`.
- `mem_addr`  out  8  memory byte address.
- `mem_wdata`  out  8  store data.
- `mem_rdata`  in  8  read data, valid in the ack cycle.
- `mem_ack`  in  1  completes the current request at this clock edge; may be high in the same cycle as `req`.
- `pc`  out  8  program counter (debug).
- `halted`  out  1  high in HALT.

## Operation
- Instruction format: byte0 = {opcode[3:0], rd[1:0], ra[1:0]}, byte1 = c. Stored at PC and PC+1.
- States: FETCH0, FETCH1, DECODE, EXEC, MEMRD, MEMWR, HALT.
- FETCH0: req=1, we=0, addr=pc. On ack: IR <= rdata, pc <= pc+1, go to FETCH1.
- FETCH1: same access. On ack: c <= rdata, pc <= pc+1, go to DECODE.
- DECODE: ea <= reg[ra] + c, 8-bit wrap-around, registered. Then branch on opcode:
  - 1000 lw: go to MEMRD.
  - 1001 sw: go to MEMWR.
  - 1010 li: din <= c, go to EXEC.
  - 1011 halt: go to HALT.
  - Any other opcode: go to EXEC.
- MEMRD: req=1, we=0, addr=ea. On ack: din <= rdata, go to EXEC.
- MEMWR: req=1, we=1, addr=ea, wdata=reg[rd] sampled in DECODE. On ack: go to FETCH0. No `en` pulse.
- EXEC: en=1 for exactly one cycle. If opcode=1111, pc <= radr. Go to FETCH0.
- HALT: outputs hold; only reset leaves it.
- `pc` wraps from 8'hFF to 8'h00. An instruction at 8'hFF takes its c byte from 8'h00.
- `mem_req` stays low in DECODE, EXEC and HALT. `mem_addr`, `mem_we` and `mem_wdata` are stable while `req`=1 and ack=0.
- `opcode`/`rd`/`ra`/`c` change only on the FETCH0/FETCH1 ack edges. They never change in the cycle `en`=1.

## Timing
- Reset values: state=FETCH0, pc=RESET_PC, opcode/rd/ra/c/din=0, en=0, mem_we=0, halted=0.
- `mem_req` is combinational from state, so it is 1 during reset.
- Reset mid-operation aborts any pending request. The first access after release is a read at RESET_PC.
- Latency with zero-wait ack: ALU/li/jmp = 4 cycles (F0, F1, DE, EX); lw = 5; sw = 4. Each wait cycle adds 1.
- The ALU captures its result at the EXEC edge. For lw, `din` is already registered one cycle earlier.
- A jump target is the `radr` value present during EXEC. This equals reg[ra]+c from the ALU.
- Ack outside a request is ignored.

## Test plan
- Reset: hold rstz=1, release -> first access is a read at 8'h00, en=0, halted=0. Bench drives zero-wait ack.
- li/add: mem = {A4,05, A8,03, 14,02, B0,00} (li r1,5; li r2,3; add r1,r1,r2; halt) -> three en pulses, opcode=0001 on the third, halted=1 at pc=8'h08. ALU model ends with reg1=8.
- Jump: op 1111 with ra=r0=0, c=8'h20 -> pc=8'h20 on the cycle after EXEC, next fetch addr=8'h20.
- lw with 3 wait states, r0=8'h10, c=8'h02, mem[12]=8'h5A -> read at 8'h12. `din`=5A before the single en pulse. Instruction takes 8 cycles.
- sw: r3=8'hC3, rd=3, ra=0, r0=8'hF0, c=8'h20 -> write at 8'h10 (wrap), wdata=C3, we=1, no en pulse.
- Reset asserted mid-FETCH1 with ack withheld -> req/addr return to read at RESET_PC. The IR byte captured in FETCH0 is cleared to 0.

Source files
------------

// File: rtl/mas8_seq.sv
// mas8_seq: instruction sequencer and memory port for the MAS8 core.
// It fetches two-byte instructions over a req/ack memory handshake, decodes
// them onto the ALU control inputs, and performs jumps, loads and stores.
//
// Ports:
//   clk            system clock, rising edge
//   rstz           asynchronous reset, active high (1 = reset)
//   reg0..reg3     ALU register values (effective address and store data)
//   radr           ALU address output, jump target sampled in EXEC
//   opcode/rd/ra   registered instruction fields from byte 0
//   c              registered second instruction byte
//   din            registered load/immediate data to the ALU
//   en             ALU enable, one-cycle pulse in EXEC
//   mem_req/mem_we/mem_addr/mem_wdata  memory request side
//   mem_rdata/mem_ack                  memory response side
//   pc             program counter (debug)
//   halted         high while in HALT
//
// state   | meaning
// FETCH0  | read instruction byte 0 at pc
// FETCH1  | read c byte at pc
// DECODE  | compute effective address, latch store data, dispatch
// EXEC    | pulse ALU enable, apply jump
// MEMRD   | read data at effective address into din
// MEMWR   | write reg[rd] to effective address
// HALT    | frozen until reset
module mas8_seq #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic [7:0] reg0,
  input  logic [7:0] reg1,
  input  logic [7:0] reg2,
  input  logic [7:0] reg3,
  input  logic [7:0] radr,
  output logic [3:0] opcode,
  output logic [1:0] rd,
  output logic [1:0] ra,
  output logic [7:0] c,
  output logic [7:0] din,
  output logic       en,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [7:0] pc,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH0 = 3'd0,
    S_FETCH1 = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEMRD  = 3'd4,
    S_MEMWR  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_LI   = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  state_t     state, state_nx;
  logic [7:0] ea;
  logic [7:0] wdata_q;
  logic [7:0] reg_a;
  logic [7:0] reg_d;

  always_comb begin
    case (ra)
      2'd0:    reg_a = reg0;
      2'd1:    reg_a = reg1;
      2'd2:    reg_a = reg2;
      default: reg_a = reg3;
    endcase
    case (rd)
      2'd0:    reg_d = reg0;
      2'd1:    reg_d = reg1;
      2'd2:    reg_d = reg2;
      default: reg_d = reg3;
    endcase
  end

  always_ff @(posedge clk or posedge rstz) begin
    if (rstz) state <= S_FETCH0;
    else      state <= state_nx;
  end

  // mem_req is decoded from state alone, so it is already high during reset
  // (state is held at FETCH0).
  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    en       = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH0: begin
        mem_req = 1'b1;
        if (mem_ack) state_nx = S_FETCH1;
      end
      S_FETCH1: begin
        mem_req = 1'b1;
        if (mem_ack) state_nx = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW:   state_nx = S_MEMRD;
          OP_SW:   state_nx = S_MEMWR;
          OP_HALT: state_nx = S_HALT;
          default: state_nx = S_EXEC;
        endcase
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        mem_addr = ea;
        if (mem_ack) state_nx = S_EXEC;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = ea;
        if (mem_ack) state_nx = S_FETCH0;
      end
      S_EXEC: begin
        en       = 1'b1;
        state_nx = S_FETCH0;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nx = S_FETCH0;
    endcase
  end

  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge rstz) begin
    if (rstz) begin
      pc      <= RESET_PC;
      opcode  <= 4'd0;
      rd      <= 2'd0;
      ra      <= 2'd0;
      c       <= 8'd0;
      din     <= 8'd0;
      ea      <= 8'd0;
      wdata_q <= 8'd0;
    end else begin
      case (state)
        S_FETCH0: if (mem_ack) begin
          {opcode, rd, ra} <= mem_rdata;
          pc               <= pc + 8'd1;
        end
        S_FETCH1: if (mem_ack) begin
          c  <= mem_rdata;
          pc <= pc + 8'd1;
        end
        S_DECODE: begin
          // Store data is frozen here so mem_wdata stays stable across waits.
          ea      <= reg_a + c;
          wdata_q <= reg_d;
          if (opcode == OP_LI) din <= c;
        end
        S_MEMRD: if (mem_ack) din <= mem_rdata;
        S_EXEC:  if (opcode == OP_JMP) pc <= radr;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mas8_seq.sv
module tb_mas8_seq;

  logic       clk = 1'b0;
  logic       rstz = 1'b1;
  logic [7:0] reg0, reg1, reg2, reg3, radr;
  logic [3:0] opcode;
  logic [1:0] rd, ra;
  logic [7:0] c, din;
  logic       en;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack;
  logic [7:0] pc;
  logic       halted;

  always #5 clk = ~clk;

  mas8_seq #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rstz(rstz),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .radr(radr),
    .opcode(opcode), .rd(rd), .ra(ra), .c(c), .din(din), .en(en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .halted(halted)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00;
  logic [7:0] ld_data = 8'h00;
  logic       ack_hold = 1'b0;
  logic       slow_on = 1'b0;
  logic [7:0] slow_addr = 8'h12;
  int         wcnt = 0;
  int         need;

  assign need      = (slow_on && mem_addr == slow_addr) ? 3 : 0;
  assign mem_ack   = !rstz && mem_req && !ack_hold && (wcnt >= need);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    if (rstz || !mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // ---------------- ALU model ----------------
  logic [7:0] r [4];
  assign reg0 = r[0];
  assign reg1 = r[1];
  assign reg2 = r[2];
  assign reg3 = r[3];
  assign radr = r[ra] + c;

  always @(posedge clk or posedge rstz) begin
    if (rstz) begin
      for (int i = 0; i < 4; i++) r[i] <= 8'h00;
    end else if (en) begin
      case (opcode)
        4'hA, 4'h8: r[rd] <= din;
        4'h1:       r[rd] <= r[rd] + r[c[1:0]];
        default:    ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       kind;   // 0 = memory access, 1 = en pulse
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;   // wdata for writes, din for en
    logic [3:0] op;
  } ev_t;
  ev_t sb[$];

  task automatic push_rd(input logic [7:0] a);
    ev_t e; e.kind = 0; e.we = 0; e.addr = a; e.data = 8'h00; e.op = 4'h0; sb.push_back(e);
  endtask
  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    ev_t e; e.kind = 0; e.we = 1; e.addr = a; e.data = d; e.op = 4'h0; sb.push_back(e);
  endtask
  task automatic push_en(input logic [3:0] o, input logic [7:0] d);
    ev_t e; e.kind = 1; e.we = 0; e.addr = 8'h00; e.data = d; e.op = o; sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rstz) begin
      if (mem_req && mem_ack) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL access_unexpected: got we=%0d addr=%h expected none", mem_we, mem_addr);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("access_kind", 16'(0), 16'(e.kind));
          chk("access_we", 16'(mem_we), 16'(e.we));
          chk("access_addr", 16'(mem_addr), 16'(e.addr));
          if (e.we) chk("access_wdata", 16'(mem_wdata), 16'(e.data));
        end
      end
      if (en) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL en_unexpected: got opcode=%h expected none", opcode);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("en_kind", 16'(1), 16'(e.kind));
          chk("en_opcode", 16'(opcode), 16'(e.op));
          chk("en_din", 16'(din), 16'(e.data));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rstz = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk(name, 16'(halted), 16'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1;
    logic seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // ---- reset state ----
    rstz = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", 16'(mem_req), 16'(1));
    chk("rst_addr", 16'(mem_addr), 16'(8'h00));
    chk("rst_we", 16'(mem_we), 16'(0));
    chk("rst_en", 16'(en), 16'(0));
    chk("rst_halted", 16'(halted), 16'(0));
    chk("rst_pc", 16'(pc), 16'(8'h00));
    chk("rst_ir", 16'({opcode, rd, ra}), 16'(8'h00));
    chk("rst_din", 16'(din), 16'(8'h00));

    // ---- li / add / halt ----
    load(8'h00, 8'hA4); load(8'h01, 8'h05);
    load(8'h02, 8'hA8); load(8'h03, 8'h03);
    load(8'h04, 8'h14); load(8'h05, 8'h02);
    load(8'h06, 8'hB0); load(8'h07, 8'h00);
    push_rd(8'h00); push_rd(8'h01); push_en(4'hA, 8'h05);
    push_rd(8'h02); push_rd(8'h03); push_en(4'hA, 8'h03);
    push_rd(8'h04); push_rd(8'h05); push_en(4'h1, 8'h03);
    push_rd(8'h06); push_rd(8'h07);
    release_reset();
    wait_halt("prog_halt", 100);
    chk("prog_pc", 16'(pc), 16'(8'h08));
    chk("prog_reg1", 16'(r[1]), 16'(8'h08));
    chk("prog_sb_empty", 16'(sb.size()), 16'(0));

    // ---- jump ----
    rstz = 1'b1;
    load(8'h00, 8'hF0); load(8'h01, 8'h20);
    load(8'h20, 8'hB0); load(8'h21, 8'h00);
    push_rd(8'h00); push_rd(8'h01); push_en(4'hF, 8'h00);
    push_rd(8'h20); push_rd(8'h21);
    release_reset();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (en) seen = 1'b1;
    end
    chk("jmp_en_seen", 16'(seen), 16'(1));
    @(negedge clk);
    chk("jmp_pc", 16'(pc), 16'(8'h20));
    chk("jmp_fetch_addr", 16'(mem_addr), 16'(8'h20));
    chk("jmp_fetch_req", 16'(mem_req), 16'(1));
    wait_halt("jmp_halt", 50);
    chk("jmp_sb_empty", 16'(sb.size()), 16'(0));

    // ---- lw with 3 wait states on the data read ----
    rstz = 1'b1;
    slow_on = 1'b1; slow_addr = 8'h12;
    load(8'h00, 8'hA0); load(8'h01, 8'h10);
    load(8'h02, 8'h84); load(8'h03, 8'h02);
    load(8'h04, 8'hB0); load(8'h05, 8'h00);
    load(8'h12, 8'h5A);
    push_rd(8'h00); push_rd(8'h01); push_en(4'hA, 8'h10);
    push_rd(8'h02); push_rd(8'h03); push_rd(8'h12); push_en(4'h8, 8'h5A);
    push_rd(8'h04); push_rd(8'h05);
    release_reset();
    t0 = 0; t1 = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack && mem_addr == 8'h02) begin t0 = cyc; seen = 1'b1; end
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (en && opcode == 4'h8) begin t1 = cyc; seen = 1'b1; end
    end
    chk("lw_en_seen", 16'(seen), 16'(1));
    chk("lw_cycles", 16'(t1 - t0 + 1), 16'(8));
    wait_halt("lw_halt", 50);
    chk("lw_reg1", 16'(r[1]), 16'(8'h5A));
    chk("lw_sb_empty", 16'(sb.size()), 16'(0));
    slow_on = 1'b0;

    // ---- sw with address wrap ----
    rstz = 1'b1;
    load(8'h00, 8'hAC); load(8'h01, 8'hC3);
    load(8'h02, 8'hA0); load(8'h03, 8'hF0);
    load(8'h04, 8'h9C); load(8'h05, 8'h20);
    load(8'h06, 8'hB0); load(8'h07, 8'h00);
    push_rd(8'h00); push_rd(8'h01); push_en(4'hA, 8'hC3);
    push_rd(8'h02); push_rd(8'h03); push_en(4'hA, 8'hF0);
    push_rd(8'h04); push_rd(8'h05); push_wr(8'h10, 8'hC3);
    push_rd(8'h06); push_rd(8'h07);
    release_reset();
    wait_halt("sw_halt", 100);
    chk("sw_mem10", 16'(mem[8'h10]), 16'(8'hC3));
    chk("sw_sb_empty", 16'(sb.size()), 16'(0));

    // ---- reset mid-FETCH1 ----
    rstz = 1'b1;
    load(8'h00, 8'hA4); load(8'h01, 8'h05);
    load(8'h02, 8'hB0); load(8'h03, 8'h00);
    push_rd(8'h00);
    release_reset();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack && mem_addr == 8'h00) seen = 1'b1;
    end
    chk("rf1_f0_ack", 16'(seen), 16'(1));
    @(posedge clk);
    #1 ack_hold = 1'b1;
    @(negedge clk);
    chk("rf1_f1_addr", 16'(mem_addr), 16'(8'h01));
    chk("rf1_ir_loaded", 16'({opcode, rd, ra}), 16'(8'hA4));
    @(negedge clk);
    rstz = 1'b1;
    #1;
    chk("rf1_rst_req", 16'(mem_req), 16'(1));
    chk("rf1_rst_addr", 16'(mem_addr), 16'(8'h00));
    chk("rf1_rst_we", 16'(mem_we), 16'(0));
    chk("rf1_rst_ir", 16'({opcode, rd, ra}), 16'(8'h00));
    chk("rf1_rst_pc", 16'(pc), 16'(8'h00));
    ack_hold = 1'b0;
    push_rd(8'h00); push_rd(8'h01); push_en(4'hA, 8'h05);
    push_rd(8'h02); push_rd(8'h03);
    @(negedge clk);
    release_reset();
    wait_halt("rf1_halt", 50);
    chk("rf1_reg1", 16'(r[1]), 16'(8'h05));
    chk("rf1_sb_empty", 16'(sb.size()), 16'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
